// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths, reset constants, opcode values
// and the fetch-stage state encoding. Imported by the fetch front end.
package cpu_pkg;

  localparam int          XLEN_DEF      = 32;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, reset_n        clock, synchronous active-low reset
//   i_load              write i_instr/i_pc into the register (valid=1)
//   i_flush             turn the register into a bubble (valid=0, NOP)
//   i_instr, i_pc       instruction and its PC to load
//   o_valid, o_instr, o_pc, o_pc_plus4  register contents
// Priority: reset > flush > load > hold. A bubble keeps its old PC.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_load,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_valid,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_pc_plus4
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_valid    <= 1'b0;
      o_instr    <= NOP_INSTR;
      o_pc       <= '0;
      o_pc_plus4 <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_instr <= NOP_INSTR;
    end else if (i_load) begin
      o_valid    <= 1'b1;
      o_instr    <= i_instr;
      o_pc       <= i_pc;
      o_pc_plus4 <= i_pc + XLEN'(4);
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch front end: owns the PC, fetches words over a req/ack
// handshake, and feeds the IF/ID register. A one-entry hold buffer absorbs
// an instruction that arrives while decode is stalled on a valid entry.
// Handshake: imem_req stays high until imem_ack; a transfer happens on
// every edge where both are high; imem_addr changes under req only on redirect.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   imem_req/addr/ack/rdata      instruction memory interface
//   redirect, redirect_pc        taken branch/jump from execute (flush)
//   stall                        decode cannot accept
//   id_valid/instr/op/pc/pc_plus4  IF/ID contents to decode
//   dbg_state                    current fetch state (S_FETCH/S_HOLD)
//   fetch_count                  IF/ID write counter (only with FETCH_STATS_EN)
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [6:0]      id_op,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            dbg_state
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_hold_instr;
  logic [XLEN-1:0] r_hold_pc;

  logic            w_ack_take;
  logic            w_load_mem;
  logic            w_to_hold;
  logic            w_load_hold;
  logic            w_load;
  logic            w_flush;
  logic [XLEN-1:0] w_ld_instr;
  logic [XLEN-1:0] w_ld_pc;

  assign imem_req  = (r_state == S_FETCH) && reset_n;
  assign imem_addr = {r_pc[XLEN-1:2], 2'b00};
  assign dbg_state = r_state;
  assign id_op     = id_instr[6:0];

  // Acks are only meaningful while requesting; a bubble in IF/ID never
  // blocks a load even when decode is stalled.
  assign w_ack_take  = (r_state == S_FETCH) && imem_ack;
  assign w_load_mem  = w_ack_take && (!stall || !id_valid);
  assign w_to_hold   = w_ack_take && stall && id_valid;
  assign w_load_hold = (r_state == S_HOLD) && !stall;
  assign w_load      = !redirect && (w_load_mem || w_load_hold);
  assign w_flush     = redirect || ((r_state == S_FETCH) && !imem_ack && !stall);
  assign w_ld_instr  = (r_state == S_HOLD) ? r_hold_instr : imem_rdata;
  assign w_ld_pc     = (r_state == S_HOLD) ? r_hold_pc : imem_addr;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else if (redirect) begin
      // Any ack this cycle is dropped and does not advance the PC.
      r_state      <= S_FETCH;
      r_pc         <= {redirect_pc[XLEN-1:2], 2'b00};
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_pc <= imem_addr + XLEN'(4);
            if (w_to_hold) begin
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= imem_addr;
              r_state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  if_id_reg #(
    .XLEN      (XLEN),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_instr    (w_ld_instr),
    .i_pc       (w_ld_pc),
    .o_valid    (id_valid),
    .o_instr    (id_instr),
    .o_pc       (id_pc),
    .o_pc_plus4 (id_pc_plus4)
  );

`ifdef FETCH_STATS_EN
  logic [31:0] r_fetch_count;

  always_ff @(posedge clk) begin
    if (!reset_n)    r_fetch_count <= '0;
    else if (w_load) r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign fetch_count = r_fetch_count;
`endif

endmodule
